// File: rtl/alu_seq_chunked.sv
// Multi-cycle ALU: WIDTH-bit operands processed CHUNK bits per cycle, LSB slice first,
// with valid/ready handshakes. Define ALU_SEQ_ADC_EN to enable ADC/SBC (arith opsel 100/101).
module alu_seq_chunked #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       opsel,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             o_flag,
  output logic             s_flag,
  output logic             op_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_x, r_y, r_acc;
  logic [WIDTH-1:0] w_x, w_y, w_acc_next;
  logic [2:0]       r_opsel;
  logic [CW-1:0]    r_cnt;
  logic             r_mode, r_carry, r_illegal, r_zacc;
  logic             w_cin, w_illegal, w_cmsb, w_last;
  logic [CHUNK-1:0] w_xs, w_ys, w_slice;
  logic [CHUNK:0]   w_sum;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign w_last = (r_cnt == LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_EXEC;
      S_EXEC:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Every arithmetic op is reduced to x + y + cin so EXEC runs a single adder slice.
  always_comb begin
    w_x       = op1;
    w_y       = op2;
    w_cin     = 1'b0;
    w_illegal = 1'b0;
    if (!mode) begin
      case (opsel)
        3'b000: ;
        3'b001: begin w_y = ~op2; w_cin = 1'b1; end
        3'b010: begin w_y = '0;   w_cin = 1'b1; end
        3'b011: w_y = '1;
`ifdef ALU_SEQ_ADC_EN
        3'b100: w_cin = c_flag;
        3'b101: begin w_y = ~op2; w_cin = c_flag; end
`else
        3'b100, 3'b101: w_illegal = 1'b1;
`endif
        3'b110: begin w_x = '0; w_y = ~op1; w_cin = 1'b1; end
        default: w_illegal = 1'b1;
      endcase
    end else begin
      w_illegal = (opsel > 3'b100);
    end
  end

  always_comb begin
    w_xs   = r_x[CHUNK-1:0];
    w_ys   = r_y[CHUNK-1:0];
    w_sum  = {1'b0, w_xs} + {1'b0, w_ys} + {{CHUNK{1'b0}}, r_carry};
    w_cmsb = w_xs[CHUNK-1] ^ w_ys[CHUNK-1] ^ w_sum[CHUNK-1];
    w_slice = '0;
    if (r_illegal)   w_slice = '0;
    else if (!r_mode) w_slice = w_sum[CHUNK-1:0];
    else begin
      case (r_opsel)
        3'b000:  w_slice = w_xs & w_ys;
        3'b001:  w_slice = w_xs | w_ys;
        3'b010:  w_slice = w_xs ^ w_ys;
        3'b011:  w_slice = ~w_xs;
        3'b100:  w_slice = ~(w_xs ^ w_ys);
        default: w_slice = '0;
      endcase
    end
    // Finished slices enter at the top and shift down, LSB slice ends at bit 0.
    w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_slice) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_opsel   <= '0;
      r_mode    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
      r_zacc    <= 1'b0;
      r_cnt     <= '0;
      result    <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      o_flag    <= 1'b0;
      s_flag    <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x       <= w_x;
          r_y       <= w_y;
          r_carry   <= w_cin;
          r_opsel   <= opsel;
          r_mode    <= mode;
          r_illegal <= w_illegal;
          r_zacc    <= 1'b1;
          r_cnt     <= '0;
        end
        S_EXEC: begin
          r_x     <= r_x >> CHUNK;
          r_y     <= r_y >> CHUNK;
          r_carry <= w_sum[CHUNK];
          r_acc   <= w_acc_next;
          r_zacc  <= r_zacc & (w_slice == '0);
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            if (r_illegal) begin
              result <= '0;
              op_err <= 1'b1;
            end else begin
              result <= w_acc_next;
              op_err <= 1'b0;
              z_flag <= r_zacc & (w_slice == '0);
              s_flag <= w_slice[CHUNK-1];
              c_flag <= r_mode ? 1'b0 : w_sum[CHUNK];
              o_flag <= r_mode ? 1'b0 : (w_sum[CHUNK] ^ w_cmsb);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_chunked.sv
// Directed bench for alu_seq_chunked: a semantic model predicts every completion and a
// compare process checks outputs on each cycle out_valid is high.
module tb_alu_seq_chunked;

  localparam int W = 128;
  localparam int C = 32;
  localparam int N = W / C;

  typedef struct packed {
    logic [W-1:0] res;
    logic c, z, o, s, err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic [2:0]   opsel = '0;
  logic         mode = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] result;
  logic         c_flag, z_flag, o_flag, s_flag, op_err;

  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t exp_cur  = '0;
  exp_t m_prev   = '0;
  logic cmp_en   = 1'b0;

  logic [W-1:0] MINS, MAXS, A, B, ONES;

  alu_seq_chunked #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
    .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endtask

  // Semantic model: signed overflow from operand/result signs, carry as "no unsigned wrap/borrow".
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic md, input exp_t prev);
    exp_t e;
    logic [W:0] full;
    logic       legal;
    e     = prev;
    legal = 1'b1;
    full  = '0;
    if (!md) begin
      case (op)
        3'd0: begin
          full = {1'b0, a} + {1'b0, b};
          e.res = full[W-1:0]; e.c = full[W];
          e.o = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        3'd1: begin
          e.res = a - b; e.c = (a >= b);
          e.o = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        3'd2: begin e.res = a + 1'b1; e.c = (a == ONES); e.o = (a == MAXS); end
        3'd3: begin e.res = a - 1'b1; e.c = (a != '0);   e.o = (a == MINS); end
`ifdef ALU_SEQ_ADC_EN
        3'd4: begin
          full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, prev.c};
          e.res = full[W-1:0]; e.c = full[W];
          e.o = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        3'd5: begin
          e.res = a - b - {{(W-1){1'b0}}, ~prev.c};
          e.c = ({1'b0, a} >= ({1'b0, b} + {{W{1'b0}}, ~prev.c}));
          e.o = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end
`endif
        3'd6: begin e.res = '0 - a; e.c = (a == '0); e.o = (a == MINS); end
        default: legal = 1'b0;
      endcase
    end else begin
      e.c = 1'b0; e.o = 1'b0;
      case (op)
        3'd0: e.res = a & b;
        3'd1: e.res = a | b;
        3'd2: e.res = a ^ b;
        3'd3: e.res = ~a;
        3'd4: e.res = ~(a ^ b);
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      e = prev;
      e.res = '0;
      e.err = 1'b1;
    end else begin
      e.z = (e.res == '0);
      e.s = e.res[W-1];
      e.err = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (cmp_en && out_valid) begin
      check("cmp_result", result, exp_cur.res);
      check_bit("cmp_c", c_flag, exp_cur.c);
      check_bit("cmp_z", z_flag, exp_cur.z);
      check_bit("cmp_o", o_flag, exp_cur.o);
      check_bit("cmp_s", s_flag, exp_cur.s);
      check_bit("cmp_err", op_err, exp_cur.err);
      check_bit("cmp_busy_in_ready", in_ready, 1'b0);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic md, input int hold);
    int n;
    logic got;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check_bit("idle_in_ready", in_ready, 1'b1);
    op1 = a; op2 = b; opsel = op; mode = md; in_valid = 1'b1;
    @(posedge clk);
    exp_cur = model(a, b, op, md, m_prev);
    cmp_en = 1'b1;
    #1;
    in_valid = 1'b0; op1 = ~a; op2 = ~b; opsel = ~op; mode = ~md;
    check_bit("exec_in_ready", in_ready, 1'b0);
    n = 0; got = 1'b0;
    while (!got && n < 4 * N + 8) begin
      @(posedge clk); #1; n++;
      got = out_valid;
    end
    check("latency", W'(n), W'(N));
    m_prev = exp_cur;
    if (hold > 0) begin
      in_valid = 1'b1; op1 = a ^ b; op2 = a; opsel = 3'd0; mode = 1'b0;
      repeat (hold) @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_bit("release_out_valid", out_valid, 1'b0);
    check_bit("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    MINS = {1'b1, {(W-1){1'b0}}};
    MAXS = ~MINS;
    ONES = '1;
    A = MINS | W'(5);
    B = MINS | W'(9);

    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_flags", W'({c_flag, z_flag, o_flag, s_flag, op_err}), '0);
    rst = 1'b0;

    run_op(A, B, 3'd0, 1'b0, 0);
    check("pin_add_res", exp_cur.res, W'(14));
    check("pin_add_czos", W'({exp_cur.c, exp_cur.z, exp_cur.o, exp_cur.s}), W'(4'b1010));

    run_op(A, B, 3'd1, 1'b0, 0);
    check("pin_sub_res", exp_cur.res, {{(W-4){1'b1}}, 4'hC});
    check("pin_sub_czos", W'({exp_cur.c, exp_cur.z, exp_cur.o, exp_cur.s}), W'(4'b0001));

    run_op(A, B, 3'd0, 1'b1, 0);
    check("pin_and_res", exp_cur.res, MINS | W'(1));
    check("pin_and_cos", W'({exp_cur.c, exp_cur.o, exp_cur.s}), W'(3'b001));

    run_op(A, B, 3'd1, 1'b1, 0);
    run_op(A, B, 3'd2, 1'b1, 0);
    check("pin_xor_res", exp_cur.res, W'(12));
    check_bit("pin_xor_z", exp_cur.z, 1'b0);

    run_op(A, A, 3'd2, 1'b1, 6);
    check("pin_xor_self_res", exp_cur.res, '0);
    check_bit("pin_xor_self_z", exp_cur.z, 1'b1);

    run_op(A, B, 3'd7, 1'b1, 0);
    check("pin_illegal", W'({exp_cur.err, exp_cur.z, exp_cur.c}), W'(3'b110));
    run_op(A, B, 3'd7, 1'b0, 0);

    run_op(MAXS, '0, 3'd2, 1'b0, 0);
    check_bit("pin_inc_o", exp_cur.o, 1'b1);
    run_op('0, B, 3'd3, 1'b0, 0);
    check("pin_dec_wrap", W'({exp_cur.c, exp_cur.res[3:0]}), W'(5'b01111));
    run_op(W'(1), '0, 3'd6, 1'b0, 0);
    run_op('0, '0, 3'd6, 1'b0, 0);
    run_op(A, B, 3'd3, 1'b1, 2);
    run_op(A, B, 3'd4, 1'b1, 0);
    run_op(A, B, 3'd6, 1'b1, 0);

    run_op(A, B, 3'd0, 1'b0, 0);
    @(negedge clk);
    op1 = A; op2 = B; opsel = 3'd0; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check("midrst_flags", W'({c_flag, z_flag, o_flag, s_flag, op_err}), '0);
    m_prev = '0;
    repeat (6) @(posedge clk);
    #1;
    check_bit("midrst_no_output", out_valid, 1'b0);

    run_op(W'(1), W'(1), 3'd0, 1'b0, 0);
    check("pin_add_1_1", exp_cur.res, W'(2));

    run_op(ONES, W'(1), 3'd0, 1'b0, 0);
    check("pin_add_wrap", W'({exp_cur.c, exp_cur.z, exp_cur.res[0]}), W'(3'b110));
    run_op('0, '0, 3'd4, 1'b0, 0);
`ifdef ALU_SEQ_ADC_EN
    check("pin_adc", W'({exp_cur.err, exp_cur.c, exp_cur.res[1:0]}), W'(4'b0001));
    run_op(W'(5), W'(7), 3'd5, 1'b0, 0);
`else
    check("pin_adc_illegal", W'({exp_cur.err, exp_cur.c, exp_cur.res[1:0]}), W'(4'b1100));
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_chunked.md
Name: alu_seq_chunked

Overview:
- Parametrised, multi-cycle successor to the 128-bit combinational arithmetic/logic unit.
- Processes WIDTH-bit operands CHUNK bits per clock through a registered carry chain, so wide datapaths close timing.
- Uses valid/ready handshakes on input and output; flags are registered and held between operations.
- Sits between the operand register file and the writeback stage.

Parameters:
WIDTH, 128, operand/result width; must be a multiple of CHUNK.
CHUNK, 32, bits processed per EXEC cycle; NCHUNK = WIDTH/CHUNK, must be ≥ 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
op1  input  WIDTH  operand A
op2  input  WIDTH  operand B
opsel  input  3  operation select
mode  input  1  0 = arithmetic, 1 = logic
out_valid  output  1  result/flags available
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
c_flag  output  1  carry (SUB/SBC/NEG: 1 = no borrow)
z_flag  output  1  result == 0
o_flag  output  1  signed overflow
s_flag  output  1  result MSB
op_err  output  1  illegal opsel/mode combination

Behaviour:
- Reset (clk edge with rst=1):
  - state = IDLE; in_ready = 1; out_valid = 0; result = 0.
  - All flags = 0; op_err = 0; chunk counter = 0.
  - rst overrides everything, including mid-EXEC and DONE; any in-flight operation is discarded without output.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch op1, op2, opsel and mode; seed carry-in; go to EXEC.
- EXEC:
  - in_ready = 0.
  - One CHUNK slice per cycle, LSB slice first; carry is registered between slices.
  - The zero detect accumulates across slices.
  - After slice NCHUNK-1, go to DONE and set out_valid = 1.
  - Latency: out_valid rises exactly NCHUNK edges after the accept edge.
- DONE:
  - result, flags and op_err are stable while out_valid = 1.
  - On out_ready: out_valid = 0 and state = IDLE; in_ready returns 1 the following cycle.
  - A request is never accepted in the same cycle as a result is released.
  - Throughput: 1 operation per NCHUNK+2 cycles when out_ready is held high.
- Flags update only on the DONE transition; they otherwise hold their previous values.
- Arithmetic (mode=0):
  - 000 ADD: op1+op2.
  - 001 SUB: op1+~op2+1.
  - 010 INC: op1+1.
  - 011 DEC: op1-1.
  - 100 ADC: op1+op2+c_flag (optional feature).
  - 101 SBC: op1+~op2+c_flag (optional feature).
  - 110 NEG: 0-op1.
  - 111: illegal.
  - c = carry out of the MSB slice.
  - o = carry into MSB XOR carry out of MSB.
  - s = result[WIDTH-1].
  - z = all result bits 0.
- Logic (mode=1):
  - 000 AND, 001 OR, 010 XOR, 011 NOT op1, 100 XNOR.
  - 101–111: illegal.
  - c = 0, o = 0; z and s are computed from the result.
- Illegal op:
  - Same latency and handshake as a legal op.
  - result = 0; op_err = 1; c/z/o/s hold their previous values.
  - op_err clears on the next legal completion.
- Wrap-around: results are modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: ALU_SEQ_ADC_EN.
- Defined: arith opsel 100/101 perform ADC/SBC using the registered c_flag from the previous completed operation, which chains multi-word arithmetic.
- Undefined: 100/101 are treated as illegal ops (result 0, op_err = 1, flags held).

Test Plan:
- WIDTH=128, CHUNK=32, ADD:
  - Stimulus: op1 = 2^127+5, op2 = 2^127+9.
  - Response: out_valid exactly 4 edges after accept; result = 14; c=1, o=1, z=0, s=0.
- SUB, same operands:
  - Response: result = 2^128−4 (0xFFFF…FFFC); c=0, o=0, z=0, s=1.
- Logic, same operands:
  - AND → 2^127+1, s=1, c=0, o=0.
  - XOR → 0xC, z=0.
  - XOR op1 with op1 → 0, z=1.
- Backpressure and illegal op:
  - Hold out_ready=0 for 6 cycles after out_valid → result/flags stable, in_ready=0, no new accept.
  - Then mode=1, opsel=111 → result 0, op_err=1, flags unchanged from the previous op.
- Reset mid-operation:
  - Assert rst on the 2nd EXEC cycle → next edge: out_valid=0, in_ready=1, all flags 0.
  - A following ADD 1+1 → result 2 after 4 cycles.
- ALU_SEQ_ADC_EN defined:
  - ADD 0xFFFF…FFFF + 1 → result 0, c=1, z=1.
  - Then ADC 0+0 → result 1, c=0.
  - With the macro undefined, the same ADC → op_err=1.
